// File: rtl/usb_readout_arbiter.sv
// Round-robin arbiter sharing the USB host read-request path among NREQ requesters.
// Each n_read strobe is answered with a byte count, then that many prefetched payload bytes.
module usb_readout_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    len,
    output logic [NREQ-1:0]      rd_en,
    input  logic [8*NREQ-1:0]    din,
    input  logic                 usb_n_read,
    input  logic                 usb_busy,
    output logic                 read_req,
    output logic [7:0]           data_out,
    output logic                 data_oe,
    output logic [NREQ-1:0]      grant,
    output logic                 timeout_err
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, LEN, DATA, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, gidx, pick;
    logic          found;
    int            cand;
    logic [7:0]    len_sel, din_sel, cnt;
    logic [15:0]   tmr;
    logic          nr_p0, nr_p1, nr_p2, nr_rise;
    logic          fetch_p1;
    logic          accept, fetch, dec, abort, finish, tmr_hit;

    // Stage p0/p1: two-flop synchroniser for the strobe; p2 holds the previous value for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nr_p0 <= 1'b1;
            nr_p1 <= 1'b1;
            nr_p2 <= 1'b1;
        end else begin
            nr_p0 <= usb_n_read;
            nr_p1 <= nr_p0;
            nr_p2 <= nr_p1;
        end
    end

    assign nr_rise = nr_p1 & ~nr_p2;
    assign tmr_hit = (TIMEOUT != 0) && (tmr == 16'(TIMEOUT - 1));
    assign len_sel = len[8*pick +: 8];
    assign din_sel = din[8*gidx +: 8];
    assign data_oe = ((state == LEN) || (state == DATA)) && !usb_n_read;

    // Search starts just after the last owner so every requester gets a turn
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && req[cand] && (len[8*cand +: 8] != 8'd0)) begin
                found = 1'b1;
                pick  = IW'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fetch     = 1'b0;
        dec       = 1'b0;
        abort     = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (found && !usb_busy) begin
                    accept    = 1'b1;
                    state_nxt = LEN;
                end
            end
            LEN: begin
                if (nr_rise) begin
                    fetch     = 1'b1;
                    state_nxt = DATA;
                end else if (tmr_hit) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end
            end
            DATA: begin
                if (nr_rise) begin
                    dec = 1'b1;
                    if (cnt == 8'd1) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        fetch = 1'b1;
                    end
                end else if (tmr_hit) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!usb_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: the requester presents its byte the cycle after rd_en, so capture one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_req    <= 1'b1;
            rd_en       <= '0;
            data_out    <= 8'd0;
            grant       <= '0;
            gidx        <= '0;
            ptr         <= IW'(NREQ - 1);
            timeout_err <= 1'b0;
            fetch_p1    <= 1'b0;
        end else begin
            timeout_err <= abort;
            rd_en       <= fetch ? grant : '0;
            fetch_p1    <= |rd_en;
            if (accept) begin
                grant    <= NREQ'(1) << pick;
                gidx     <= pick;
                read_req <= 1'b0;
                data_out <= len_sel;
            end
            if ((state == LEN) && (state_nxt != LEN)) read_req <= 1'b1;
            if (fetch_p1) data_out <= din_sel;
            if (finish || abort) begin
                grant <= '0;
                ptr   <= gidx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)   cnt <= len_sel;
        else if (dec) cnt <= cnt - 8'd1;
        if (accept || nr_rise)                    tmr <= 16'd0;
        else if ((state == LEN) || (state == DATA)) tmr <= tmr + 16'd1;
    end

endmodule

// File: doc/usb_readout_arbiter.md
Name: usb_readout_arbiter

Overview:
- Shares the USB host interface's read-request path among 4 readout requesters, e.g. ASIC readout FIFOs and the housekeeping block.
- Round-robin picks one requester with pending data and drives the interface's active-low read request.
- Answers the interface's n_read strobes on the shared data bus: first a byte count, then that many payload bytes fetched from the granted requester.
- Sits between the requesters and the host interface's read_req/data/n_read/busy pins, in the same clock domain.

Parameters:
- NREQ, 4, number of requesters; fixed at 4 in this revision.
- TIMEOUT, 65535, clk cycles allowed between n_read strobes before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- req  in  4  level per requester: data pending.
- len  in  32  4x8-bit byte counts; requester i uses bits 8i+7:8i; sampled only at grant.
- rd_en  out  4  one-cycle fetch pulse to the granted requester.
- din  in  32  4x8-bit data; lane i must be valid the cycle after rd_en[i].
- usb_n_read  in  1  read strobe from the host interface, active-low; asynchronous to the arbiter's state.
- usb_busy  in  1  host interface busy.
- read_req  out  1  read request to the host interface, active-low.
- data_out  out  8  byte presented to the host interface.
- data_oe  out  1  bus drive enable for data_out.
- grant  out  4  one-hot owner of the current transfer; 0 when idle.
- timeout_err  out  1  one-cycle pulse on abort.

Behaviour:
- Reset values (asynchronous, immediate on reset assertion, including mid-transfer):
  - read_req=1, rd_en=0, data_out=0, grant=0, timeout_err=0, state=IDLE.
  - Round-robin pointer=3, so requester 0 has first priority after reset.
  - n_read synchronisers reset to 1.
- Strobe synchroniser: usb_n_read passes through 2 flops to give nr_s. A strobe completes on a rising edge of nr_s.
- Drive enable: data_oe = (state is LEN or DATA) AND NOT usb_n_read. This is combinational on the raw pin so the bus is driven while the strobe is low.
- States:
  - IDLE:
    - Eligible requesters are those with req[i]=1 and len_i!=0.
    - If any are eligible and usb_busy=0, choose the first eligible index after the pointer, wrapping.
    - Then latch cnt=len_i, set grant, set data_out=len_i, set read_req=0, go to LEN.
    - A requester with len=0 is never granted.
  - LEN:
    - On nr_s rising: set read_req=1, pulse rd_en[g] for one cycle, go to DATA.
    - data_out loads din lane g on the cycle after rd_en.
  - DATA:
    - On nr_s rising: decrement cnt.
    - If the new cnt=0, go to DONE with no further rd_en.
    - Otherwise pulse rd_en[g] and load the next byte the following cycle.
  - DONE:
    - Clear grant and set the pointer to g.
    - Go to IDLE the first cycle usb_busy=0; minimum 1 cycle in DONE.
- Fetch accounting: exactly len rd_en pulses per transfer.
- Strobe spacing: the host interface holds n_read high for at least 4 clk between strobes, so a prefetch always completes before the next strobe. This is not checked in RTL.
- Timeout:
  - A 16-bit counter clears on entry to LEN and on every nr_s rising edge, and counts in LEN and DATA.
  - On reaching TIMEOUT (when TIMEOUT!=0): pulse timeout_err, set read_req=1, go to DONE.
  - The pointer still advances, so a stalled requester cannot starve the others.
- Inputs outside the granted transfer:
  - req and len changes during a transfer are ignored.
  - rd_en is never issued to a non-granted requester.
- Strobe arriving in IDLE or DONE: ignored. data_oe=0 and no state change.

Test Plan:
- Single requester: req[0]=1 with len0=3, data bytes A1, A2, A3. Expect:
  - read_req falls 1 cycle after acceptance; the first strobe reads 0x03 and read_req rises.
  - The next strobes read A1, A2, A3; exactly 3 rd_en[0] pulses; grant=0001 until DONE.
- Round-robin: req=1111 held, all len=1, usb_busy=0. Expect grant sequence 0001, 0010, 0100, 1000, 0001.
- Busy and len=0 gating:
  - usb_busy=1 while req[2]=1: read_req stays 1 until busy falls.
  - req[1]=1 with len1=0: never granted.
- Timeout: TIMEOUT=20, grant with len=5, stop strobes after 2 data bytes. Expect:
  - timeout_err pulses 20 cycles after the last strobe; read_req=1.
  - The next eligible requester is granted after busy=0.
- Maximum length: len3=255. Expect 255 rd_en[3] pulses and a byte-count byte of 0xFF; cnt reaches 0 with no extra fetch.
- Reset mid-transfer: assert reset during DATA. Expect immediate read_req=1, grant=0, data_oe=0; after release, requester 0 has first priority.
